// File: rtl/trap_controller.sv
// trap_controller
//   Classifies synchronous exceptions coming from the decode stage and
//   NUM_EXT external fault sources. It resolves them by fixed priority and
//   latches the S-mode trap CSRs (scause, sepc, stval). It then runs the
//   trap-entry sequence: a FLUSH_CYCLES-long pipeline flush followed by a
//   ready/valid redirect to stvec. It also turns an sret in IDLE into a
//   redirect to sepc.
//
// Ports
//   clk, reset       clock, synchronous active-low reset
//   instr_valid      instruction/pc/mem_addr valid this cycle
//   instruction      instruction from ID (ILEN)
//   pc, mem_addr     pc of the instruction and load/store effective address
//   ext_exc          level-sensitive external exception requests (NUM_EXT)
//   stvec            trap vector base
//   sret             sret retiring this cycle
//   exception_flag   one-cycle pulse on trap capture
//   scause/sepc/stval latched trap CSRs
//   flush            pipeline flush request
//   redirect_valid/redirect_ready/redirect_pc  redirect handshake to fetch
//   busy             high while in FLUSH or REDIRECT
//   trap_count       saturating count of captured traps (CNT_W)
module trap_controller #(
  parameter int XLEN           = 64,
  parameter int ILEN           = 32,
  parameter int NUM_EXT        = 2,
  parameter int EXT_CAUSE_BASE = 24,
  parameter int FLUSH_CYCLES   = 2,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [ILEN-1:0]    instruction,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    mem_addr,
  input  logic [NUM_EXT-1:0] ext_exc,
  input  logic [XLEN-1:0]    stvec,
  input  logic               sret,
  output logic               exception_flag,
  output logic [31:0]        scause,
  output logic [XLEN-1:0]    sepc,
  output logic [XLEN-1:0]    stval,
  output logic               flush,
  output logic               redirect_valid,
  input  logic               redirect_ready,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               busy,
  output logic [CNT_W-1:0]   trap_count
);

  // The down-counter only has to hold FLUSH_CYCLES-1.
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_ILLEGAL = 7'h7F;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [FCW-1:0]     flush_cnt_r;
  logic               capture_s;
  logic               sret_take_s;
  logic               exc_hit_s;
  logic [31:0]        exc_cause_s;
  logic [XLEN-1:0]    exc_tval_s;
  logic [6:0]         opcode_s;
  logic [1:0]         stvec_unused_s;

  logic               exception_flag_r;
  logic [31:0]        scause_r;
  logic [XLEN-1:0]    sepc_r;
  logic [XLEN-1:0]    stval_r;
  logic               flush_r;
  logic               redirect_valid_r;
  logic [XLEN-1:0]    redirect_pc_r;
  logic               busy_r;
  logic [CNT_W-1:0]   trap_count_r;

  // Access of 1<<funct3[1:0] bytes is misaligned when any low address bit
  // inside the access size is set.
  function automatic logic mem_misaligned(input logic [2:0] funct3,
                                          input logic [2:0] addr_lo);
    logic [2:0] mask;
    case (funct3[1:0])
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return (addr_lo & mask) != 3'b000;
  endfunction

  // The vector is forced to 4-byte alignment, so the low bits are dropped.
  assign stvec_unused_s = stvec[1:0];
  assign opcode_s       = instruction[6:0];

  // Priority classification of the current exception condition.
  always_comb begin
    exc_hit_s   = 1'b0;
    exc_cause_s = 32'd0;
    exc_tval_s  = '0;
    if (instr_valid && (pc[1:0] != 2'b00)) begin
      exc_hit_s   = 1'b1;
      exc_cause_s = 32'd0;
      exc_tval_s  = pc;
    end else if (instr_valid && ((opcode_s == OPC_ILLEGAL) || (instruction == '0))) begin
      exc_hit_s   = 1'b1;
      exc_cause_s = 32'd2;
      exc_tval_s  = XLEN'(instruction);
    end else if (instr_valid && (instruction == ILEN'(32'h0000_0073))) begin
      exc_hit_s   = 1'b1;
      exc_cause_s = 32'd9;
      exc_tval_s  = '0;
    end else if (instr_valid && (opcode_s == OPC_LOAD) &&
                 mem_misaligned(instruction[14:12], mem_addr[2:0])) begin
      exc_hit_s   = 1'b1;
      exc_cause_s = 32'd4;
      exc_tval_s  = mem_addr;
    end else if (instr_valid && (opcode_s == OPC_STORE) &&
                 mem_misaligned(instruction[14:12], mem_addr[2:0])) begin
      exc_hit_s   = 1'b1;
      exc_cause_s = 32'd6;
      exc_tval_s  = mem_addr;
    end else if (ext_exc != '0) begin
      exc_hit_s  = 1'b1;
      exc_tval_s = mem_addr;
      // Scan downward so the lowest set index is the last one written.
      for (int i = NUM_EXT - 1; i >= 0; i--) begin
        if (ext_exc[i]) begin
          exc_cause_s = 32'(EXT_CAUSE_BASE + i);
        end else begin
          exc_cause_s = exc_cause_s;
        end
      end
    end else begin
      exc_hit_s = 1'b0;
    end
  end

  // Next-state logic; exceptions and sret are only looked at in IDLE.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    sret_take_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (exc_hit_s) begin
          capture_s    = 1'b1;
          state_next_s = FLUSH;
        end else if (sret) begin
          sret_take_s  = 1'b1;
          state_next_s = REDIRECT;
        end else begin
          state_next_s = IDLE;
        end
      end
      FLUSH: begin
        if (flush_cnt_r == '0) begin
          state_next_s = REDIRECT;
        end else begin
          state_next_s = FLUSH;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = REDIRECT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs, trap CSRs, flush down-counter and trap counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exception_flag_r <= 1'b0;
      scause_r         <= 32'd0;
      sepc_r           <= '0;
      stval_r          <= '0;
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
      busy_r           <= 1'b0;
      trap_count_r     <= '0;
      flush_cnt_r      <= '0;
    end else begin
      exception_flag_r <= capture_s;
      flush_r          <= (state_next_s == FLUSH);
      redirect_valid_r <= (state_next_s == REDIRECT);
      busy_r           <= (state_next_s != IDLE);
      if (capture_s) begin
        scause_r      <= exc_cause_s;
        sepc_r        <= pc;
        stval_r       <= exc_tval_s;
        redirect_pc_r <= {stvec[XLEN-1:2], 2'b00};
        flush_cnt_r   <= FCW'(FLUSH_CYCLES - 1);
        if (trap_count_r != '1) begin
          trap_count_r <= trap_count_r + CNT_W'(1);
        end else begin
          trap_count_r <= trap_count_r;
        end
      end else if (sret_take_s) begin
        redirect_pc_r <= sepc_r;
      end else if ((state_r == FLUSH) && (flush_cnt_r != '0)) begin
        flush_cnt_r <= flush_cnt_r - FCW'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign exception_flag = exception_flag_r;
  assign scause         = scause_r;
  assign sepc           = sepc_r;
  assign stval          = stval_r;
  assign flush          = flush_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign busy           = busy_r;
  assign trap_count     = trap_count_r;

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller
//   Directed scenarios followed by randomized traffic. Every cycle the DUT
//   outputs are compared against a transaction-level reference model of the
//   trap rules. A second instance with a 2-bit counter shares the stimulus
//   to exercise trap_count saturation.
module tb_trap_controller;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic [63:0] mem_addr;
  logic [1:0]  ext_exc;
  logic [63:0] stvec;
  logic        sret;
  logic        redirect_ready;

  logic        exception_flag, flush, redirect_valid, busy;
  logic [31:0] scause;
  logic [63:0] sepc, stval, redirect_pc;
  logic [15:0] trap_count;

  logic        d2_flag, d2_flush, d2_rv, d2_busy;
  logic [31:0] d2_scause;
  logic [63:0] d2_sepc, d2_stval, d2_rpc;
  logic [1:0]  d2_count;

  always #5 clk = ~clk;

  trap_controller dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .pc(pc), .mem_addr(mem_addr), .ext_exc(ext_exc), .stvec(stvec), .sret(sret),
    .exception_flag(exception_flag), .scause(scause), .sepc(sepc), .stval(stval),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .busy(busy), .trap_count(trap_count)
  );

  trap_controller #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .pc(pc), .mem_addr(mem_addr), .ext_exc(ext_exc), .stvec(stvec), .sret(sret),
    .exception_flag(d2_flag), .scause(d2_scause), .sepc(d2_sepc), .stval(d2_stval),
    .flush(d2_flush), .redirect_valid(d2_rv), .redirect_ready(redirect_ready),
    .redirect_pc(d2_rpc), .busy(d2_busy), .trap_count(d2_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: remaining flush cycles, pending redirect, CSRs.
  int          m_flush_left;
  bit          m_redir;
  bit          m_flag;
  logic [31:0] m_cause;
  logic [63:0] m_epc, m_tval, m_rpc;
  int          m_traps;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Trap rules in priority order, written directly from the cause table.
  function automatic void classify(output bit hit, output logic [31:0] c, output logic [63:0] tv);
    int op, sz;
    op  = int'(instruction & 32'h7F);
    sz  = 1 << int'((instruction >> 12) & 32'h3);
    hit = 1'b1; c = 32'd0; tv = 64'd0;
    if (instr_valid && (pc % 64'd4) != 64'd0) begin
      c = 32'd0; tv = pc;
    end else if (instr_valid && (op == 127 || instruction == 32'd0)) begin
      c = 32'd2; tv = {32'd0, instruction};
    end else if (instr_valid && instruction == 32'h73) begin
      c = 32'd9; tv = 64'd0;
    end else if (instr_valid && op == 3 && (mem_addr % 64'(sz)) != 64'd0) begin
      c = 32'd4; tv = mem_addr;
    end else if (instr_valid && op == 35 && (mem_addr % 64'(sz)) != 64'd0) begin
      c = 32'd6; tv = mem_addr;
    end else if (ext_exc[0]) begin
      c = 32'd24; tv = mem_addr;
    end else if (ext_exc[1]) begin
      c = 32'd25; tv = mem_addr;
    end else begin
      hit = 1'b0;
    end
  endfunction

  task automatic model_edge();
    bit          hit;
    logic [31:0] c;
    logic [63:0] tv;
    if (!reset) begin
      m_flush_left = 0; m_redir = 0; m_flag = 0;
      m_cause = 0; m_epc = 0; m_tval = 0; m_rpc = 0; m_traps = 0;
      return;
    end
    m_flag = 0;
    if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) m_redir = 1;
    end else if (m_redir) begin
      if (redirect_ready) m_redir = 0;
    end else begin
      classify(hit, c, tv);
      if (hit) begin
        m_cause = c; m_epc = pc; m_tval = tv;
        m_rpc = stvec & ~64'h3;
        m_traps++;
        m_flag = 1;
        m_flush_left = FC;
      end else if (sret) begin
        m_redir = 1;
        m_rpc = m_epc;
      end
    end
  endtask

  task automatic compare_all();
    check("exception_flag", exception_flag, m_flag);
    check("flush", flush, m_flush_left > 0);
    check("redirect_valid", redirect_valid, m_redir);
    check("busy", busy, (m_flush_left > 0) || m_redir);
    check("scause", scause, m_cause);
    check("sepc", sepc, m_epc);
    check("stval", stval, m_tval);
    check("redirect_pc", redirect_pc, m_rpc);
    check("trap_count", trap_count, (m_traps > 65535) ? 65535 : m_traps);
    check("trap_count_sat", d2_count, (m_traps > 3) ? 3 : m_traps);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic quiet();
    instr_valid = 1'b0; instruction = 32'h0000_0033; ext_exc = 2'b00; sret = 1'b0;
  endtask

  initial begin
    reset = 1'b0; quiet(); pc = 64'd0; mem_addr = 64'd0; stvec = 64'd0; redirect_ready = 1'b1;
    run(2);
    check("rst_scause", scause, 64'd0);
    check("rst_rv", redirect_valid, 64'd0);
    check("rst_count", trap_count, 64'd0);
    reset = 1'b1;

    // Illegal instruction trap and full entry sequence.
    stvec = 64'h1000_0003; instr_valid = 1'b1; instruction = 32'hFFFF_FFFF; pc = 64'h80;
    step();
    check("ill_flag", exception_flag, 64'd1);
    check("ill_scause", scause, 64'd2);
    check("ill_sepc", sepc, 64'h80);
    check("ill_stval", stval, 64'hFFFF_FFFF);
    check("ill_count", trap_count, 64'd1);
    quiet();
    step();
    check("ill_flush2", flush, 64'd1);
    check("ill_flag_clr", exception_flag, 64'd0);
    step();
    check("ill_flush_end", flush, 64'd0);
    check("ill_rv", redirect_valid, 64'd1);
    check("ill_rpc", redirect_pc, 64'h1000_0000);
    step();
    check("ill_idle", busy, 64'd0);

    // Priority: misaligned fetch beats illegal; load misaligned beats ext.
    instr_valid = 1'b1; instruction = 32'hFFFF_FFFF; pc = 64'h82;
    step();
    check("prio_scause0", scause, 64'd0);
    check("prio_stval0", stval, 64'h82);
    quiet(); run(3);
    instr_valid = 1'b1; instruction = 32'h0000_2003; pc = 64'h100; mem_addr = 64'h102; ext_exc = 2'b11;
    step();
    check("prio_scause4", scause, 64'd4);
    check("prio_stval4", stval, 64'h102);
    quiet(); run(3);

    // External source 1 and a stalled redirect handshake.
    ext_exc = 2'b10; redirect_ready = 1'b0;
    step();
    check("ext_scause", scause, 64'd25);
    quiet(); run(2);
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_rv", redirect_valid, 64'd1);
      check("hold_rpc", redirect_pc, 64'h1000_0000);
      check("hold_busy", busy, 64'd1);
    end
    redirect_ready = 1'b1;
    step();
    check("hs_rv_clr", redirect_valid, 64'd0);
    check("hs_busy_clr", busy, 64'd0);

    // sret returns to sepc; sret with ecall is dropped.
    instr_valid = 1'b1; instruction = 32'h0000_0073; pc = 64'h200;
    step();
    quiet(); run(3);
    sret = 1'b1;
    step();
    check("sret_rv", redirect_valid, 64'd1);
    check("sret_rpc", redirect_pc, 64'h200);
    check("sret_flush", flush, 64'd0);
    check("sret_flag", exception_flag, 64'd0);
    check("sret_scause", scause, 64'd9);
    sret = 1'b0;
    step();
    instr_valid = 1'b1; instruction = 32'h0000_0073; pc = 64'h300; sret = 1'b1;
    step();
    check("sret_ecall_flag", exception_flag, 64'd1);
    check("sret_ecall_sepc", sepc, 64'h300);
    quiet(); run(2);
    check("sret_ecall_rpc", redirect_pc, 64'h1000_0000);
    step();

    // Misaligned sh during FLUSH is ignored.
    instr_valid = 1'b1; instruction = 32'h0000_0073; pc = 64'h400;
    step();
    instruction = 32'h0000_1023; mem_addr = 64'h11; pc = 64'h404;
    step();
    check("busy_scause", scause, 64'd9);
    check("busy_sepc", sepc, 64'h400);
    quiet(); run(2);
    check("sat_count", d2_count, 64'd3);
    check("full_count", trap_count, 64'd7);

    // Reset while in REDIRECT.
    redirect_ready = 1'b0; instr_valid = 1'b1; instruction = 32'h0000_0073; pc = 64'h500;
    step();
    quiet(); run(2);
    check("pre_rst_rv", redirect_valid, 64'd1);
    reset = 1'b0;
    step();
    check("mid_rst_rv", redirect_valid, 64'd0);
    check("mid_rst_busy", busy, 64'd0);
    check("mid_rst_sepc", sepc, 64'd0);
    check("mid_rst_rpc", redirect_pc, 64'd0);
    check("mid_rst_count", trap_count, 64'd0);
    reset = 1'b1; redirect_ready = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int kind;
      logic [31:0] f3;
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      instr_valid = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 7);
      f3 = 32'($urandom_range(0, 7)) << 12;
      case (kind)
        0: instruction = 32'hFFFF_FFFF;
        1: instruction = 32'h0000_0000;
        2: instruction = 32'h0000_0073;
        3: instruction = ($urandom & 32'hFFFF_8F80) | f3 | 32'h03;
        4: instruction = ($urandom & 32'hFFFF_8F80) | f3 | 32'h23;
        default: instruction = ($urandom & 32'hFFFF_FF80) | 32'h33;
      endcase
      pc = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) pc = pc & ~64'h3;
      mem_addr = {$urandom, $urandom};
      ext_exc = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      sret = ($urandom_range(0, 9) == 0);
      redirect_ready = ($urandom_range(0, 1) == 1);
      stvec = {$urandom, $urandom};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Parametrised successor to the single-cycle exception detector.
- Classifies synchronous exceptions from the decode stage plus NUM_EXT external fault sources, and resolves them by fixed priority.
- Latches the S-mode trap CSRs (scause, sepc, stval).
- Runs a trap-entry sequence: multi-cycle pipeline flush, then a ready/valid redirect to stvec. Also handles sret return to sepc.
- Sits between ID/IF and the control unit / PC-select logic.

Parameters:
- XLEN, 64, width of pc, mem_addr, stvec, sepc, stval, redirect_pc.
- ILEN, 32, instruction width.
- NUM_EXT, 2, number of external exception sources (≥1).
- EXT_CAUSE_BASE, 24, scause code of ext source 0; source i reports EXT_CAUSE_BASE+i.
- FLUSH_CYCLES, 2, cycles flush is held (≥1).
- CNT_W, 16, width of the trap counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- instr_valid  in  1  instruction/pc/mem_addr valid this cycle.
- instruction  in  ILEN  instruction from ID.
- pc  in  XLEN  pc of the instruction.
- mem_addr  in  XLEN  effective address for load/store.
- ext_exc  in  NUM_EXT  external exception requests, level, sampled in IDLE.
- stvec  in  XLEN  trap vector base.
- sret  in  1  sret retiring this cycle.
- exception_flag  out  1  one-cycle pulse on trap capture, to control unit.
- scause  out  32  latched cause.
- sepc  out  XLEN  latched faulting pc.
- stval  out  XLEN  latched trap value.
- flush  out  1  pipeline flush request.
- redirect_valid  out  1  redirect_pc valid.
- redirect_ready  in  1  fetch accepts redirect.
- redirect_pc  out  XLEN  new fetch pc.
- busy  out  1  high in FLUSH or REDIRECT.
- trap_count  out  CNT_W  saturating count of captured traps.

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. Reset mid-sequence abandons any pending flush or redirect.
- FSM states: IDLE, FLUSH, REDIRECT.
- Detection is evaluated only in IDLE. Conditions, in priority order, highest first:
  - fetch misaligned: instr_valid && pc[1:0]!=0. cause 0, stval=pc.
  - illegal: instr_valid && (opcode==7'h7F || instruction==0). cause 2, stval=zero-extended instruction.
  - ecall: instr_valid && instruction==32'h00000073. cause 9, stval=0.
  - load misaligned: instr_valid && opcode==7'b0000011 && mem_addr&(size-1)!=0, with size=1<<funct3[1:0]. cause 4, stval=mem_addr.
  - store misaligned: same test with opcode 7'b0100011. cause 6, stval=mem_addr.
  - ext: any ext_exc bit set, independent of instr_valid; lowest index wins. cause EXT_CAUSE_BASE+i, stval=mem_addr.
- Capture, at edge N in IDLE when any condition holds:
  - Latch scause, sepc=pc, stval.
  - Latch redirect target = {stvec[XLEN-1:2],2'b00}.
  - trap_count+1, saturating at all-ones.
  - Go to FLUSH.
  - Cycle N+1: exception_flag=1 for exactly one cycle.
- FLUSH:
  - flush=1 on cycles N+1 … N+FLUSH_CYCLES, counted by an internal down-counter.
  - After the last flush cycle, go to REDIRECT.
- REDIRECT:
  - redirect_valid=1 with redirect_pc held stable until redirect_ready=1 at an edge.
  - Next cycle: redirect_valid=0, back in IDLE.
  - If redirect_ready is already high on entry, the handshake completes in one cycle.
- sret:
  - In IDLE with no exception condition: go directly to REDIRECT with redirect_pc=sepc.
  - No flush, no exception_flag; CSRs and trap_count unchanged.
  - If an exception and sret occur in the same cycle, the exception wins and sret is dropped.
- Busy window: in FLUSH/REDIRECT, busy=1 and all new exceptions and sret are ignored. They are not queued; CSRs hold.
- CSR hold: scause/sepc/stval hold their values until the next capture.
- Back-to-back traps: re-arm when the FSM returns to IDLE. A persistent ext_exc re-traps on the first IDLE cycle.

Test Plan:
- Illegal trap: reset, stvec=0x1000_0003, instr_valid with instruction=0xFFFF_FFFF, pc=0x80 →
  - next cycle: exception_flag=1, scause=2, sepc=0x80, stval=0xFFFF_FFFF.
  - flush high 2 cycles, then redirect_valid with redirect_pc=0x1000_0000.
  - trap_count=1.
- Priority: pc=0x82 with illegal opcode → scause=0, stval=0x82. Then a lw (funct3=010) at mem_addr=0x102 with ext_exc=2'b11 → scause=4, stval=0x102.
- Ext source and handshake: ext_exc=2'b10 with instr_valid=0 → scause=25. Hold redirect_ready=0 for 5 cycles → redirect_valid and redirect_pc stable; busy=1 throughout. Release ready → IDLE the next cycle.
- sret: after a trap with sepc=0x200, pulse sret in IDLE → redirect_pc=0x200, no flush, exception_flag=0, CSRs unchanged. sret together with ecall → scause=9, sret dropped.
- Ignored during busy: a misaligned sh (funct3=001) at mem_addr=0x11 issued during FLUSH → no capture, scause unchanged.
- Reset mid-sequence: reset=0 during REDIRECT → next cycle all outputs 0, FSM in IDLE.
- Counter saturation: with CNT_W=2, five traps → trap_count stays 3.
